// File: rtl/sys_array_ctrl_if.sv
// rtl/sys_array_ctrl_if.sv - host/control bundle of the systolic-array operand-feed sequencer
interface sys_array_ctrl_if #(
    parameter int M  = 2,
    parameter int K  = 4,
    parameter int AW = 16
) ();
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            error;
    logic            acc_clr;
    logic [M-1:0]    a_vld;
    logic [M*AW-1:0] a_addr;
    logic [K-1:0]    b_vld;
    logic [K*AW-1:0] b_addr;
    logic [31:0]     cycle_cnt;

    // Host side: launches and cancels products, observes status and operand fetches
    modport master (
        output start, abort,
        input  busy, done, error, acc_clr, a_vld, a_addr, b_vld, b_addr, cycle_cnt
    );

    // Sequencer side
    modport slave (
        input  start, abort,
        output busy, done, error, acc_clr, a_vld, a_addr, b_vld, b_addr, cycle_cnt
    );
endinterface

// File: rtl/sys_array_ctrl.sv
// rtl/sys_array_ctrl.sv - skewed operand-feed sequencer for an MxN by NxK systolic array
module sys_array_ctrl #(
    parameter int M      = 2,
    parameter int N      = 3,
    parameter int K      = 4,
    parameter int PE_LAT = 4,
    parameter int AW     = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    sys_array_ctrl_if.slave   bus
);
    localparam int MK    = (M > K) ? M : K;
    localparam int T_LEN = N + MK - 1;
    localparam int D_LEN = PE_LAT + M + K - 2;
    localparam int TW    = $clog2(T_LEN) + 1;
    localparam int DW    = $clog2(D_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            error_q, error_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            acc_clr_q, acc_clr_d;
    logic [M-1:0]    a_vld_q, a_vld_d;
    logic [M*AW-1:0] a_addr_q, a_addr_d;
    logic [K-1:0]    b_vld_q, b_vld_d;
    logic [K*AW-1:0] b_addr_q, b_addr_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    int              tt;

    // State register and registered outputs; reset returns everything to idle zeros
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            drain_q     <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_clr_q   <= 1'b0;
            a_vld_q     <= '0;
            a_addr_q    <= '0;
            b_vld_q     <= '0;
            b_addr_q    <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            drain_q     <= drain_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_clr_q   <= acc_clr_d;
            a_vld_q     <= a_vld_d;
            a_addr_q    <= a_addr_d;
            b_vld_q     <= b_vld_d;
            b_addr_q    <= b_addr_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // Next state, feed/drain counters and the sticky start-while-busy flag
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        drain_d = drain_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    error_d = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == TW'(T_LEN - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(D_LEN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    error_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over a simultaneous start; a lone start while busy is flagged
        if (state_q == S_CLEAR || state_q == S_FEED || state_q == S_DRAIN) begin
            if (bus.abort) begin
                state_d = S_IDLE;
            end else if (bus.start) begin
                error_d = 1'b1;
            end
        end
    end

    // Output values for the coming cycle, derived from the next state so they can be registered
    always_comb begin
        busy_d      = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        acc_clr_d   = (state_d == S_CLEAR);
        a_vld_d     = '0;
        a_addr_d    = '0;
        b_vld_d     = '0;
        b_addr_d    = '0;
        tt          = int'(t_d);
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == S_CLEAR) begin
            cycle_cnt_d = 32'd1;
        end else if (state_d != S_IDLE) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (state_d == S_FEED) begin
            // Row i of A enters i cycles late; walks along the row (row-major A)
            for (int i = 0; i < M; i++) begin
                if (tt >= i && tt <= i + N - 1) begin
                    a_vld_d[i]              = 1'b1;
                    a_addr_d[i*AW +: AW]    = AW'(i * N + (tt - i));
                end
            end
            // Column j of B enters j cycles late; walks down the column (row-major B)
            for (int j = 0; j < K; j++) begin
                if (tt >= j && tt <= j + N - 1) begin
                    b_vld_d[j]              = 1'b1;
                    b_addr_d[j*AW +: AW]    = AW'((tt - j) * K + j);
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.a_vld     = a_vld_q;
    assign bus.a_addr    = a_addr_q;
    assign bus.b_vld     = b_vld_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_sys_array_ctrl.sv
// tb/tb_sys_array_ctrl.sv - directed self-checking bench for sys_array_ctrl
module tb_sys_array_ctrl;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    sys_array_ctrl_if #(.M(2), .K(4), .AW(AW)) bus_a ();
    sys_array_ctrl_if #(.M(4), .K(1), .AW(AW)) bus_b ();

    sys_array_ctrl #(.M(2), .N(3), .K(4), .PE_LAT(4), .AW(AW)) dut_a (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus_a.slave)
    );

    sys_array_ctrl #(.M(4), .N(2), .K(1), .PE_LAT(3), .AW(AW)) dut_b (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus_b.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] snap_a();
        return 160'({bus_a.busy, bus_a.done, bus_a.error, bus_a.acc_clr, bus_a.a_vld,
                     bus_a.a_addr, bus_a.b_vld, bus_a.b_addr, bus_a.cycle_cnt});
    endfunction

    function automatic logic [159:0] snap_b();
        return 160'({bus_b.busy, bus_b.done, bus_b.error, bus_b.acc_clr, bus_b.a_vld,
                     bus_b.a_addr, bus_b.b_vld, bus_b.b_addr, bus_b.cycle_cnt});
    endfunction

    // Cycle k is the cycle after the k-th edge following the sampled start (k=1 is CLEAR)
    int          r_clr, r_feed, r_drain, r_done_k, r_ndone, r_busy_late;
    int          r_err1, r_err_end, r_abort_busy, r_abort_vld;
    logic [31:0] r_cnt_end;

    task automatic run_a(input int ncyc, input int start_k, input int abort_k, input bit do_skew);
        r_clr = 0; r_feed = 0; r_drain = 0; r_done_k = 0; r_ndone = 0; r_busy_late = 0;
        r_err1 = 0; r_err_end = 0; r_abort_busy = -1; r_abort_vld = -1;
        bus_a.start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            bus_a.start = (k == start_k);
            bus_a.abort = (k == abort_k);
            if (bus_a.acc_clr) r_clr++;
            if (bus_a.a_vld != '0 || bus_a.b_vld != '0) r_feed++;
            else if (bus_a.busy && !bus_a.acc_clr) r_drain++;
            if (bus_a.done) begin
                r_ndone++;
                if (r_done_k == 0) r_done_k = k;
            end
            if (r_done_k != 0 && bus_a.busy) r_busy_late++;
            if (k == 1) r_err1 = int'(bus_a.error);
            if (k == abort_k + 1) begin
                r_abort_busy = int'(bus_a.busy);
                r_abort_vld  = int'({bus_a.a_vld, bus_a.b_vld});
            end
            if (do_skew && k == 2) begin
                check_vec("t0_a_vld", 160'(bus_a.a_vld), 160'(2'b01));
                check_vec("t0_a_addr", 160'(bus_a.a_addr), 160'd0);
                check_vec("t0_b_vld", 160'(bus_a.b_vld), 160'(4'b0001));
                check_vec("t0_b_addr", 160'(bus_a.b_addr), 160'd0);
            end
            if (do_skew && k == 4) begin
                check_vec("t2_a_vld", 160'(bus_a.a_vld), 160'(2'b11));
                check_vec("t2_a_addr1", 160'(bus_a.a_addr[AW +: AW]), 160'd4);
                check_vec("t2_a_addr0", 160'(bus_a.a_addr[0 +: AW]), 160'd2);
                check_vec("t2_b_vld", 160'(bus_a.b_vld), 160'(4'b0111));
                check_vec("t2_b_addr2", 160'(bus_a.b_addr[2*AW +: AW]), 160'd2);
                check_vec("t2_b_addr0", 160'(bus_a.b_addr[0 +: AW]), 160'd8);
                check_vec("t2_b_addr1", 160'(bus_a.b_addr[AW +: AW]), 160'd5);
                check_vec("t2_b_addr3", 160'(bus_a.b_addr[3*AW +: AW]), 160'd0);
            end
            if (do_skew && k == 7) begin
                check_vec("t5_a_vld", 160'(bus_a.a_vld), 160'd0);
                check_vec("t5_b_vld", 160'(bus_a.b_vld), 160'(4'b1000));
                check_vec("t5_b_addr3", 160'(bus_a.b_addr[3*AW +: AW]), 160'd11);
                check_vec("t5_a_addr", 160'(bus_a.a_addr), 160'd0);
            end
        end
        r_err_end = int'(bus_a.error);
        r_cnt_end = bus_a.cycle_cnt;
    endtask

    int          n_done_rst, n_busy_rst, b_done_k;
    logic [31:0] a3_mask, b0_mask;

    initial begin
        nrst = 1'b0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_a", snap_a(), 160'd0);
        check_vec("reset_b", snap_b(), 160'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Plain product at defaults with skew snapshots
        run_a(24, -1, -1, 1'b1);
        check_vec("clr_cycles", 160'(r_clr), 160'd1);
        check_vec("feed_cycles", 160'(r_feed), 160'd6);
        check_vec("drain_cycles", 160'(r_drain), 160'd8);
        check_vec("done_cycle", 160'(r_done_k), 160'd16);
        check_vec("done_pulses", 160'(r_ndone), 160'd1);
        check_vec("busy_after_done", 160'(r_busy_late), 160'd0);
        check_vec("cycle_cnt", 160'(r_cnt_end), 160'd16);
        check_vec("error_clean", 160'(r_err_end), 160'd0);

        // Start during FEED flags error but does not disturb the run
        run_a(24, 4, -1, 1'b0);
        check_vec("err_run_done", 160'(r_done_k), 160'd16);
        check_vec("err_run_pulses", 160'(r_ndone), 160'd1);
        check_vec("err_sticky", 160'(r_err_end), 160'd1);
        check_vec("err_run_cnt", 160'(r_cnt_end), 160'd16);

        // Next accepted start clears error
        run_a(24, -1, -1, 1'b0);
        check_vec("err_cleared", 160'(r_err1), 160'd0);
        check_vec("after_err_done", 160'(r_done_k), 160'd16);

        // Abort in the 3rd DRAIN cycle (cycle 10)
        run_a(20, -1, 10, 1'b0);
        check_vec("abort_busy", 160'(r_abort_busy), 160'd0);
        check_vec("abort_vld", 160'(r_abort_vld), 160'd0);
        check_vec("abort_no_done", 160'(r_ndone), 160'd0);
        check_vec("abort_cnt_hold", 160'(r_cnt_end), 160'd10);

        // Full product after abort
        run_a(24, -1, -1, 1'b0);
        check_vec("post_abort_done", 160'(r_done_k), 160'd16);
        check_vec("post_abort_cnt", 160'(r_cnt_end), 160'd16);

        // Reset while in FEED (t=2)
        run_a(4, -1, -1, 1'b0);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check_vec("rst_mid_feed", snap_a(), 160'd0);
        nrst = 1'b1;
        n_done_rst = 0;
        n_busy_rst = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus_a.done) n_done_rst++;
            if (bus_a.busy) n_busy_rst++;
        end
        check_vec("rst_no_done", 160'(n_done_rst), 160'd0);
        check_vec("rst_idle", 160'(n_busy_rst), 160'd0);

        // Alternate geometry: M=4 N=2 K=1 PE_LAT=3
        a3_mask  = '0;
        b0_mask  = '0;
        b_done_k = 0;
        bus_b.start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            bus_b.start = 1'b0;
            if (bus_b.a_vld[3]) a3_mask[k] = 1'b1;
            if (bus_b.b_vld[0]) b0_mask[k] = 1'b1;
            if (bus_b.done && b_done_k == 0) b_done_k = k;
        end
        check_vec("b_a3_window", 160'(a3_mask), 160'h60);
        check_vec("b_b0_window", 160'(b0_mask), 160'h0C);
        check_vec("b_done_cycle", 160'(b_done_k), 160'd13);
        check_vec("b_cycle_cnt", 160'(bus_b.cycle_cnt), 160'd13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
